regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between two writers: the in-order pipeline writeback (requester A) and a long-latency functional unit such as mul/div (requester B). B results are buffered in a small FIFO while A holds the port. A per-register pending scoreboard marks destinations of in-flight B operations, so decode can stall reads that would return stale data. The block sits between writeback and the register file's WriteData/rd/RegWrite inputs.

## Interface
- XLEN, 64, data width; must match the register file.
- FIFO_DEPTH, 2, B-side buffer entries; must be ≥1.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  pipeline writeback request; always accepted, no ready.
- a_rd  in  5  A destination register.
- a_data  in  XLEN  A write data.
- b_valid  in  1  long-latency unit result valid.
- b_ready  out  1  B handshake; a transfer occurs when b_valid & b_ready.
- b_rd  in  5  B destination register.
- b_data  in  XLEN  B result data.
- issue_valid  in  1  a B-unit operation is issued this cycle.
- issue_rd  in  5  destination of the issued operation.
- rs1, rs2  in  5 each  decode read addresses.
- rs1_pending, rs2_pending  out  1 each  combinational: pending[rsN] & (rsN != 0).
- wb_bubble_req  out  1  FIFO full; the pipeline must insert a writeback bubble.
- wr_en  out  1  drives register file RegWrite (registered).
- wr_rd  out  5  drives rd (registered).
- wr_data  out  XLEN  drives WriteData (registered).

## Operation
- Each cycle, select at most one source, in priority order:
  - A, if a_valid & a_rd != 0.
  - FIFO head, if the FIFO is non-empty.
  - B direct (bypass), if b_valid & b_ready & FIFO empty.
- The selected source loads wr_en=1, wr_rd, wr_data at the next posedge. With no selection, wr_en=0 and wr_rd/wr_data hold their values.
- b_ready = (count < FIFO_DEPTH) & ~reset.
- An accepted B transfer that is not taken by the bypass path is enqueued.
- Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- FIFO order is strict; pointers wrap modulo FIFO_DEPTH.
- x0 handling:
  - A with a_rd=0 counts as no request.
  - B with b_rd=0 is accepted and discarded: never enqueued, never written.
  - issue_rd=0 sets nothing.
- Scoreboard: pending[31:1] bits.
  - issue_valid sets pending[issue_rd].
  - A B-sourced write clears pending[wr_rd] on the posedge that ends the cycle in which wr_en is high, which is the edge where the register file captures the data.
  - A registered source tag distinguishes B writes from A writes; A writes never clear pending bits.
  - If a set and a clear hit the same register on one edge, set wins.
- wb_bubble_req = (count == FIFO_DEPTH).
- The pipeline guarantees that A never targets a register whose pending bit is set (no WAW). The block does not check this.

## Timing
- Reset (synchronous, sampled on posedge): wr_en=0, wr_rd=0, wr_data=0, FIFO empty (count=0), all pending=0, b_ready=0 while reset is high, wb_bubble_req=0.
- A latency: request in cycle n → wr_en high in cycle n+1 → register file updated at the end of n+1.
- B bypass latency matches A: 1 cycle.
- A queued B entry writes in the first cycle in which A is not requesting, with FIFO order preserved.
- Pending clears at the end of the B write cycle. rsN_pending therefore drops in the first cycle in which a combinational read of the register file returns the new value.
- A asserted every cycle starves the FIFO. When the FIFO fills, b_ready drops and wb_bubble_req rises. The first A-idle cycle drains one entry, and b_ready returns high in the following cycle.
- Reset asserted mid-operation discards FIFO contents and pending bits in that same edge. No write issues in the cycle after reset.

## Test plan
- Reset then idle: after reset=1 for one edge, all outputs are 0; after reset falls, b_ready=1 and wr_en stays 0.
- A alone: a_valid=1, a_rd=5, a_data=0xAA in cycle 0 → cycle 1 shows wr_en=1, wr_rd=5, wr_data=0xAA; cycle 2 shows wr_en=0.
- Collision: A(rd=3, 0x11) and B(rd=7, 0x22) in cycle 0, A idle afterwards → cycle 1 writes rd 3 with 0x11; cycle 2 writes rd 7 with 0x22; count returns to 0.
- Backpressure: A valid continuously while B offers 3 results (FIFO_DEPTH=2) → after 2 acceptances, b_ready=0 and wb_bubble_req=1; drop a_valid for one cycle → the head is written and b_ready rises the next cycle; order is preserved.
- Scoreboard: issue_rd=9 in cycle 0; rs1=9 → rs1_pending=1 from cycle 1. B bypass write to rd 9 in cycle k (wr_en high) → rs1_pending=0 from cycle k+1. Issue and clear of rd 9 on the same edge → pending stays 1.
- x0 and reset: a_rd=0 produces no write. b_rd=0 with b_valid=1 completes the handshake, and no write or enqueue follows. Reset with 2 FIFO entries and pending[4]=1 → both cleared and no write occurs afterwards.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (A) and a
// long-latency unit (B), with a small B-side FIFO and a per-register pending scoreboard.
module regfile_write_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_pending,
    output logic            rs2_pending,
    output logic            wb_bubble_req,
    output logic            wr_en,
    output logic [4:0]      wr_rd,
    output logic [XLEN-1:0] wr_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        wr_from_b;

    logic a_req;
    logic fifo_empty;
    logic b_fire;
    logic b_keep;
    logic deq;
    logic bypass;
    logic enq;

    assign b_ready       = (count < DEPTH_C) & ~reset;
    assign wb_bubble_req = (count == DEPTH_C);
    assign rs1_pending   = pending[rs1] & (rs1 != 5'd0);
    assign rs2_pending   = pending[rs2] & (rs2 != 5'd0);

    // Source selection: A first, then the FIFO head, then B bypass only when the FIFO is empty.
    // B results addressed to x0 are handshaken but dropped.
    always_comb begin
        a_req      = a_valid & (a_rd != 5'd0);
        fifo_empty = (count == '0);
        b_fire     = b_valid & b_ready;
        b_keep     = b_fire & (b_rd != 5'd0);
        deq        = ~a_req & ~fifo_empty;
        bypass     = ~a_req & fifo_empty & b_keep;
        enq        = b_keep & ~bypass;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[tail]   <= b_rd;
            fifo_data[tail] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
            end
            if (deq) begin
                head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // wr_from_b tags the registered write so only B-sourced writes retire pending bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_rd     <= '0;
            wr_data   <= '0;
            wr_from_b <= 1'b0;
        end else if (a_req) begin
            wr_en     <= 1'b1;
            wr_rd     <= a_rd;
            wr_data   <= a_data;
            wr_from_b <= 1'b0;
        end else if (deq) begin
            wr_en     <= 1'b1;
            wr_rd     <= fifo_rd[head];
            wr_data   <= fifo_data[head];
            wr_from_b <= 1'b1;
        end else if (bypass) begin
            wr_en     <= 1'b1;
            wr_rd     <= b_rd;
            wr_data   <= b_data;
            wr_from_b <= 1'b1;
        end else begin
            wr_en     <= 1'b0;
            wr_from_b <= 1'b0;
        end
    end

    // The clear is applied before the set so a same-edge issue to the same register wins.
    always_comb begin
        pending_next = pending;
        if (wr_en & wr_from_b) begin
            pending_next[wr_rd] = 1'b0;
        end
        if (issue_valid & (issue_rd != 5'd0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter with hand-computed
// expectations, plus hand-written reset sequences.
module tb_regfile_write_arbiter;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_pending;
    logic            rs2_pending;
    logic            wb_bubble_req;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic            av;
        logic [4:0]      ard;
        logic [XLEN-1:0] adata;
        logic            bv;
        logic [4:0]      brd;
        logic [XLEN-1:0] bdata;
        logic            iv;
        logic [4:0]      ird;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic            e_en;
        logic [4:0]      e_rd;
        logic [XLEN-1:0] e_data;
        logic            e_bready;
        logic            e_bubble;
        logic            e_p1;
        logic            e_p2;
    } vec_t;

    vec_t vecs[$];

    regfile_write_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_pending  (rs1_pending),
        .rs2_pending  (rs2_pending),
        .wb_bubble_req(wb_bubble_req),
        .wr_en        (wr_en),
        .wr_rd        (wr_rd),
        .wr_data      (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(
        input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adata,
        input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bdata,
        input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
        input logic e_en, input logic [4:0] e_rd, input logic [XLEN-1:0] e_data,
        input logic e_bready, input logic e_bubble, input logic e_p1, input logic e_p2);
        vec_t v;
        v.av = av;  v.ard = ard;  v.adata = adata;
        v.bv = bv;  v.brd = brd;  v.bdata = bdata;
        v.iv = iv;  v.ird = ird;  v.r1 = r1;  v.r2 = r2;
        v.e_en = e_en;  v.e_rd = e_rd;  v.e_data = e_data;
        v.e_bready = e_bready;  v.e_bubble = e_bubble;
        v.e_p1 = e_p1;  v.e_p2 = e_p2;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        a_valid     = v.av;
        a_rd        = v.ard;
        a_data      = v.adata;
        b_valid     = v.bv;
        b_rd        = v.brd;
        b_data      = v.bdata;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        rs1         = v.r1;
        rs2         = v.r2;
    endtask

    task automatic setIdle();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;

        // Row table: pre-edge combinational expectations, then post-edge write port.
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  0,0,'h0,    1,0,0,0);
        addVec(1,5,'hAA,    0,0,0,       0,0, 0,0,  1,5,'hAA,   1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  0,5,'hAA,   1,0,0,0);
        addVec(1,3,'h11,    1,7,'h22,    0,0, 0,0,  1,3,'h11,   1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  1,7,'h22,   1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  0,7,'h22,   1,0,0,0);
        addVec(1,1,'h101,   1,10,'hB0,   0,0, 0,0,  1,1,'h101,  1,0,0,0);
        addVec(1,2,'h102,   1,11,'hB1,   0,0, 0,0,  1,2,'h102,  1,0,0,0);
        addVec(1,3,'h103,   1,12,'hB2,   0,0, 0,0,  1,3,'h103,  0,1,0,0);
        addVec(0,0,0,       1,12,'hB2,   0,0, 0,0,  1,10,'hB0,  0,1,0,0);
        addVec(1,4,'h104,   1,12,'hB2,   0,0, 0,0,  1,4,'h104,  1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  1,11,'hB1,  0,1,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  1,12,'hB2,  1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  0,12,'hB2,  1,0,0,0);
        addVec(0,0,0,       0,0,0,       1,9, 9,0,  0,12,'hB2,  1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 9,0,  0,12,'hB2,  1,0,1,0);
        addVec(0,0,0,       1,9,'h99,    0,0, 9,0,  1,9,'h99,   1,0,1,0);
        addVec(0,0,0,       0,0,0,       0,0, 9,0,  0,9,'h99,   1,0,1,0);
        addVec(0,0,0,       0,0,0,       0,0, 9,0,  0,9,'h99,   1,0,0,0);
        addVec(0,0,0,       0,0,0,       1,9, 9,0,  0,9,'h99,   1,0,0,0);
        addVec(0,0,0,       1,9,'h98,    0,0, 9,0,  1,9,'h98,   1,0,1,0);
        addVec(0,0,0,       0,0,0,       1,9, 9,0,  0,9,'h98,   1,0,1,0);
        addVec(0,0,0,       0,0,0,       0,0, 9,0,  0,9,'h98,   1,0,1,0);
        addVec(1,9,'h77,    0,0,0,       0,0, 9,0,  1,9,'h77,   1,0,1,0);
        addVec(0,0,0,       0,0,0,       0,0, 9,0,  0,9,'h77,   1,0,1,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,9,  0,9,'h77,   1,0,0,1);
        addVec(1,0,'h55,    0,0,0,       0,0, 0,9,  0,9,'h77,   1,0,0,1);
        addVec(0,0,0,       1,0,'h66,    0,0, 0,0,  0,9,'h77,   1,0,0,0);
        addVec(0,0,0,       0,0,0,       0,0, 0,0,  0,9,'h77,   1,0,0,0);

        $display("[TB] reset check");
        stepCycle();
        checkOutput("reset wr_en", wr_en, 0);
        checkOutput("reset wr_rd", wr_rd, 0);
        checkOutput("reset wr_data", wr_data, 0);
        checkOutput("reset b_ready", b_ready, 0);
        checkOutput("reset wb_bubble_req", wb_bubble_req, 0);
        checkOutput("reset rs1_pending", rs1_pending, 0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset b_ready", b_ready, 1);

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row %0d b_ready", i), b_ready, vecs[i].e_bready);
            checkOutput($sformatf("row %0d wb_bubble_req", i), wb_bubble_req, vecs[i].e_bubble);
            checkOutput($sformatf("row %0d rs1_pending", i), rs1_pending, vecs[i].e_p1);
            checkOutput($sformatf("row %0d rs2_pending", i), rs2_pending, vecs[i].e_p2);
            stepCycle();
            checkOutput($sformatf("row %0d wr_en", i), wr_en, vecs[i].e_en);
            checkOutput($sformatf("row %0d wr_rd", i), wr_rd, vecs[i].e_rd);
            checkOutput($sformatf("row %0d wr_data", i), wr_data, vecs[i].e_data);
        end

        $display("[TB] mid-operation reset with full FIFO and pending rd 4");
        setIdle();
        a_valid = 1; a_rd = 1; a_data = 'h201;
        b_valid = 1; b_rd = 20; b_data = 'hC0;
        issue_valid = 1; issue_rd = 4;
        stepCycle();
        setIdle();
        a_valid = 1; a_rd = 2; a_data = 'h202;
        b_valid = 1; b_rd = 21; b_data = 'hC1;
        stepCycle();
        checkOutput("fill wr_rd", wr_rd, 2);
        setIdle();
        rs1 = 4;
        reset = 1'b1;
        #1;
        checkOutput("mid-reset b_ready", b_ready, 0);
        checkOutput("mid-reset full bubble", wb_bubble_req, 1);
        checkOutput("mid-reset rs1_pending before edge", rs1_pending, 1);
        stepCycle();
        checkOutput("mid-reset wr_en", wr_en, 0);
        checkOutput("mid-reset wr_rd", wr_rd, 0);
        checkOutput("mid-reset wr_data", wr_data, 0);
        checkOutput("mid-reset bubble cleared", wb_bubble_req, 0);
        checkOutput("mid-reset rs1_pending cleared", rs1_pending, 0);
        reset = 1'b0;
        #1;
        checkOutput("after mid-reset b_ready", b_ready, 1);
        stepCycle();
        checkOutput("after mid-reset wr_en cycle 1", wr_en, 0);
        stepCycle();
        checkOutput("after mid-reset wr_en cycle 2", wr_en, 0);
        checkOutput("after mid-reset rs1_pending", rs1_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
